// File: rtl/riscv_core_csr_pkg.sv
//==============================================================================
// Module  : riscv_core_csr_pkg
// Brief   : Shared constants for the M-mode CSR file and trap sequencer:
//           CSR addresses, exception cause codes, mstatus bit positions,
//           CSR op encodings (funct3[1:0]) and the trap FSM state type.
//           The counter CSR addresses are only decoded when
//           RISCV_CSR_COUNTERS_EN is defined.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package riscv_core_csr_pkg;

  // CSR addresses
  localparam logic [11:0] c_addr_mstatus   = 12'h300;
  localparam logic [11:0] c_addr_misa      = 12'h301;
  localparam logic [11:0] c_addr_mtvec     = 12'h305;
  localparam logic [11:0] c_addr_mscratch  = 12'h340;
  localparam logic [11:0] c_addr_mepc      = 12'h341;
  localparam logic [11:0] c_addr_mcause    = 12'h342;
  localparam logic [11:0] c_addr_mtval     = 12'h343;
  localparam logic [11:0] c_addr_mcycle    = 12'hB00;
  localparam logic [11:0] c_addr_minstret  = 12'hB02;
  localparam logic [11:0] c_addr_mcycleh   = 12'hB80;
  localparam logic [11:0] c_addr_minstreth = 12'hB82;

  // Synchronous exception cause codes
  localparam logic [31:0] c_cause_illegal    = 32'd2;
  localparam logic [31:0] c_cause_breakpoint = 32'd3;
  localparam logic [31:0] c_cause_ecall_m    = 32'd11;

  // mstatus bit positions; MPP is hardwired to machine mode
  localparam int          c_mstatus_mie    = 3;
  localparam int          c_mstatus_mpie   = 7;
  localparam int          c_mstatus_mpp_lo = 11;
  localparam int          c_mstatus_mpp_hi = 12;
  localparam logic [1:0]  c_mpp_machine    = 2'b11;

  // CSR op encodings in funct3[1:0]; funct3[2] selects the zimm operand
  localparam logic [1:0]  c_op_rw = 2'b01;
  localparam logic [1:0]  c_op_rs = 2'b10;
  localparam logic [1:0]  c_op_rc = 2'b11;

  // Trap sequencer states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_TRAP     = 2'd1,
    ST_MRET     = 2'd2,
    ST_REDIRECT = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/riscv_core_csr_regfile.sv
//==============================================================================
// Module  : riscv_core_csr_regfile
// Brief   : M-mode CSR storage, address decode, combinational read mux and
//           CSRRW/RS/RC write masking. Trap entry and MRET side effects on
//           mepc/mcause/mtval/mstatus are applied here when the sequencer
//           asks for them. Optional 64-bit mcycle/minstret counters are
//           built when RISCV_CSR_COUNTERS_EN is defined.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module riscv_core_csr_regfile
  import riscv_core_csr_pkg::*;
#(
  parameter int             XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_MTVEC = 32'h0000_0100,
  parameter logic [XLEN-1:0] MISA_VAL    = 32'h4000_0100
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [11:0]     i_addr,
  output logic [XLEN-1:0] o_rdata,
  output logic            o_addr_known,
  output logic            o_addr_ro,
  input  logic            i_wen,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_operand,
  input  logic            i_trap,
  input  logic [XLEN-1:0] i_trap_pc,
  input  logic [XLEN-1:0] i_trap_cause,
  input  logic [XLEN-1:0] i_trap_tval,
  input  logic            i_mret,
  input  logic            i_retire,
  output logic [XLEN-1:0] o_mtvec,
  output logic [XLEN-1:0] o_mepc,
  output logic            o_mie
);

  logic            r_mie;
  logic            r_mpie;
  logic [XLEN-1:0] r_mtvec;
  logic [XLEN-1:0] r_mscratch;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mcause;
  logic [XLEN-1:0] r_mtval;
  logic [XLEN-1:0] w_mstatus;
  logic [XLEN-1:0] w_wdata;

`ifdef RISCV_CSR_COUNTERS_EN
  logic [63:0]     r_mcycle;
  logic [63:0]     r_minstret;
`endif

  // Assemble the architectural mstatus view from the two live bits
  always_comb begin
    w_mstatus                                  = '0;
    w_mstatus[c_mstatus_mpp_hi:c_mstatus_mpp_lo] = c_mpp_machine;
    w_mstatus[c_mstatus_mpie]                  = r_mpie;
    w_mstatus[c_mstatus_mie]                   = r_mie;
  end

  // Address decode and read mux; unknown addresses read as zero
  always_comb begin
    o_rdata      = '0;
    o_addr_known = 1'b1;
    o_addr_ro    = 1'b0;
    case (i_addr)
      c_addr_mstatus:   o_rdata = w_mstatus;
      c_addr_misa: begin
        o_rdata   = MISA_VAL;
        o_addr_ro = 1'b1;
      end
      c_addr_mtvec:     o_rdata = r_mtvec;
      c_addr_mscratch:  o_rdata = r_mscratch;
      c_addr_mepc:      o_rdata = r_mepc;
      c_addr_mcause:    o_rdata = r_mcause;
      c_addr_mtval:     o_rdata = r_mtval;
`ifdef RISCV_CSR_COUNTERS_EN
      c_addr_mcycle:    o_rdata = XLEN'(r_mcycle[31:0]);
      c_addr_mcycleh:   o_rdata = XLEN'(r_mcycle[63:32]);
      c_addr_minstret:  o_rdata = XLEN'(r_minstret[31:0]);
      c_addr_minstreth: o_rdata = XLEN'(r_minstret[63:32]);
`endif
      default:          o_addr_known = 1'b0;
    endcase
  end

  // Read-modify-write value for the current CSR op (funct3[1:0]==00 keeps old)
  always_comb begin
    case (i_op)
      c_op_rw: w_wdata = i_operand;
      c_op_rs: w_wdata = o_rdata | i_operand;
      c_op_rc: w_wdata = o_rdata & ~i_operand;
      default: w_wdata = o_rdata;
    endcase
  end

  // Architectural CSR state: trap entry, MRET, then ordinary CSR writes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mie      <= 1'b0;
      r_mpie     <= 1'b0;
      r_mtvec    <= {RESET_MTVEC[XLEN-1:2], 2'b00};
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mtval    <= '0;
    end else if (i_trap) begin
      r_mepc     <= {i_trap_pc[XLEN-1:2], 2'b00};
      r_mcause   <= i_trap_cause;
      r_mtval    <= i_trap_tval;
      r_mpie     <= r_mie;
      r_mie      <= 1'b0;
    end else if (i_mret) begin
      r_mie      <= r_mpie;
      r_mpie     <= 1'b1;
    end else if (i_wen) begin
      case (i_addr)
        c_addr_mstatus: begin
          r_mie  <= w_wdata[c_mstatus_mie];
          r_mpie <= w_wdata[c_mstatus_mpie];
        end
        c_addr_mtvec:    r_mtvec    <= {w_wdata[XLEN-1:2], 2'b00};
        c_addr_mscratch: r_mscratch <= w_wdata;
        c_addr_mepc:     r_mepc     <= {w_wdata[XLEN-1:2], 2'b00};
        c_addr_mcause:   r_mcause   <= w_wdata;
        c_addr_mtval:    r_mtval    <= w_wdata;
        default: ;
      endcase
    end
  end

`ifdef RISCV_CSR_COUNTERS_EN
  logic w_wr_cycle_lo;
  logic w_wr_cycle_hi;
  logic w_wr_instret_lo;
  logic w_wr_instret_hi;

  assign w_wr_cycle_lo   = i_wen && (i_addr == c_addr_mcycle);
  assign w_wr_cycle_hi   = i_wen && (i_addr == c_addr_mcycleh);
  assign w_wr_instret_lo = i_wen && (i_addr == c_addr_minstret);
  assign w_wr_instret_hi = i_wen && (i_addr == c_addr_minstreth);

  // Free-running counters; a write to either half suppresses that cycle's increment
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mcycle   <= '0;
      r_minstret <= '0;
    end else begin
      if (w_wr_cycle_lo)        r_mcycle[31:0]    <= w_wdata[31:0];
      else if (w_wr_cycle_hi)   r_mcycle[63:32]   <= w_wdata[31:0];
      else                      r_mcycle          <= r_mcycle + 64'd1;

      if (w_wr_instret_lo)      r_minstret[31:0]  <= w_wdata[31:0];
      else if (w_wr_instret_hi) r_minstret[63:32] <= w_wdata[31:0];
      else if (i_retire)        r_minstret        <= r_minstret + 64'd1;
    end
  end
`else
  logic w_retire_unused;
  assign w_retire_unused = i_retire;
`endif

  assign o_mtvec = r_mtvec;
  assign o_mepc  = r_mepc;
  assign o_mie   = r_mie;

endmodule

`default_nettype wire

// File: rtl/riscv_core_csr_trap_unit.sv
//==============================================================================
// Module  : riscv_core_csr_trap_unit
// Brief   : Machine-mode CSR execution and trap sequencer. Decides CSR ops,
//           prioritises synchronous exceptions, and walks IDLE -> TRAP/MRET ->
//           REDIRECT to emit a one-cycle redirect+flush two cycles after the
//           triggering instruction, stalling upstream while busy.
//           Optional counters: define RISCV_CSR_COUNTERS_EN.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module riscv_core_csr_trap_unit
  import riscv_core_csr_pkg::*;
#(
  parameter int             XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_MTVEC = 32'h0000_0100,
  parameter logic [XLEN-1:0] MISA_VAL    = 32'h4000_0100
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic            i_ecall,
  input  logic            i_ebreak,
  input  logic            i_mret,
  input  logic            i_sret,
  input  logic            i_csr_wen,
  input  logic            i_illegal,
  output logic [XLEN-1:0] o_csr_rdata,
  output logic            o_stall,
  output logic            o_flush,
  output logic            o_redirect,
  output logic [XLEN-1:0] o_redirect_pc,
  output logic            o_mie
);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_redirect_pc;

  logic [2:0]      w_funct3;
  logic [4:0]      w_rs1_field;
  logic [11:0]     w_csr_addr;
  logic            w_fire;
  logic            w_csr_op;
  logic            w_csr_writes;
  logic            w_csr_bad;
  logic [XLEN-1:0] w_operand;
  logic            w_trap;
  logic [XLEN-1:0] w_cause;
  logic [XLEN-1:0] w_tval;
  logic            w_mret_go;
  logic            w_csr_wen;
  logic            w_retire;
  logic            w_addr_known;
  logic            w_addr_ro;
  logic [XLEN-1:0] w_mtvec;
  logic [XLEN-1:0] w_mepc;

  assign w_funct3    = i_instr[14:12];
  assign w_rs1_field = i_instr[19:15];
  assign w_csr_addr  = i_instr[31:20];

  // Only an IDLE-state valid instruction can have any architectural effect
  assign w_fire    = i_valid && (r_state == ST_IDLE);
  assign w_csr_op  = w_fire && i_csr_wen && (w_funct3 != 3'b000);
  assign w_operand = w_funct3[2] ? XLEN'(w_rs1_field) : i_rs1_data;

  // RS/RC with a zero rs1 field are pure reads; funct3=100 is treated as a read
  assign w_csr_writes = (w_funct3[1:0] == c_op_rw) ||
                        ((w_funct3[1:0] != 2'b00) && (w_rs1_field != 5'd0));
  assign w_csr_bad    = w_csr_op && (!w_addr_known || (w_addr_ro && w_csr_writes));

  // Exception prioritisation: first matching source wins
  always_comb begin
    w_trap  = 1'b0;
    w_cause = '0;
    w_tval  = '0;
    if (w_fire) begin
      if (i_illegal || i_sret) begin
        w_trap  = 1'b1;
        w_cause = XLEN'(c_cause_illegal);
        w_tval  = XLEN'(i_instr);
      end else if (w_csr_bad) begin
        w_trap  = 1'b1;
        w_cause = XLEN'(c_cause_illegal);
        w_tval  = XLEN'(i_instr);
      end else if (i_ecall) begin
        w_trap  = 1'b1;
        w_cause = XLEN'(c_cause_ecall_m);
        w_tval  = '0;
      end else if (i_ebreak) begin
        w_trap  = 1'b1;
        w_cause = XLEN'(c_cause_breakpoint);
        w_tval  = i_pc;
      end
    end
  end

  assign w_mret_go = w_fire && i_mret && !w_trap;
  assign w_csr_wen = w_csr_op && w_csr_writes && !w_trap;
  assign w_retire  = w_fire && !w_trap;

  riscv_core_csr_regfile #(
    .XLEN        (XLEN),
    .RESET_MTVEC (RESET_MTVEC),
    .MISA_VAL    (MISA_VAL)
  ) u_regfile (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_addr       (w_csr_addr),
    .o_rdata      (o_csr_rdata),
    .o_addr_known (w_addr_known),
    .o_addr_ro    (w_addr_ro),
    .i_wen        (w_csr_wen),
    .i_op         (w_funct3[1:0]),
    .i_operand    (w_operand),
    .i_trap       (w_trap),
    .i_trap_pc    (i_pc),
    .i_trap_cause (w_cause),
    .i_trap_tval  (w_tval),
    .i_mret       (w_mret_go),
    .i_retire     (w_retire),
    .o_mtvec      (w_mtvec),
    .o_mepc       (w_mepc),
    .o_mie        (o_mie)
  );

  // Sequencer state register; reset drops any in-flight redirect
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Sequencer next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_trap)         w_state_nxt = ST_TRAP;
        else if (w_mret_go) w_state_nxt = ST_MRET;
      end
      ST_TRAP, ST_MRET: w_state_nxt = ST_REDIRECT;
      ST_REDIRECT:      w_state_nxt = ST_IDLE;
      default:          w_state_nxt = ST_IDLE;
    endcase
  end

  // Sequencer outputs: stall while busy, redirect/flush only in REDIRECT
  always_comb begin
    o_stall    = (r_state != ST_IDLE);
    o_redirect = (r_state == ST_REDIRECT);
    o_flush    = (r_state == ST_REDIRECT);
  end

  // Capture the redirect target one cycle after the trigger, once mepc is settled
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                  r_redirect_pc <= '0;
    else if (r_state == ST_TRAP)   r_redirect_pc <= w_mtvec;
    else if (r_state == ST_MRET)   r_redirect_pc <= w_mepc;
  end

  assign o_redirect_pc = r_redirect_pc;

endmodule

`default_nettype wire

// File: tb/tb_riscv_core_csr_trap_unit.sv
//==============================================================================
// Module  : tb_riscv_core_csr_trap_unit
// Brief   : Self-checking bench for riscv_core_csr_trap_unit. Directed
//           scenarios followed by randomized instructions checked against a
//           behavioural CSR/trap model. Counter checks depend on
//           RISCV_CSR_COUNTERS_EN.
// Revision: 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_riscv_core_csr_trap_unit;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic        ecall, ebreak, mret, sret, csr_wen, illegal;
  logic [31:0] csr_rdata;
  logic        stall, flush, redirect, mie;
  logic [31:0] redirect_pc;

  int n_checks   = 0;
  int n_failures = 0;

  // Behavioural model: CSR contents by address plus the two mstatus bits
  logic [31:0] m_csr [int];
  bit          m_mie;
  bit          m_mpie;

  logic [11:0] rnd_addrs [8] = '{12'h300, 12'h301, 12'h305, 12'h340,
                                 12'h341, 12'h342, 12'h343, 12'h7C0};
  logic [2:0]  rnd_f3s   [6] = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};

  riscv_core_csr_trap_unit #(
    .XLEN        (32),
    .RESET_MTVEC (32'h0000_0100),
    .MISA_VAL    (32'h4000_0100)
  ) u_dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_valid       (valid),
    .i_instr       (instr),
    .i_pc          (pc),
    .i_rs1_data    (rs1_data),
    .i_ecall       (ecall),
    .i_ebreak      (ebreak),
    .i_mret        (mret),
    .i_sret        (sret),
    .i_csr_wen     (csr_wen),
    .i_illegal     (illegal),
    .o_csr_rdata   (csr_rdata),
    .o_stall       (stall),
    .o_flush       (flush),
    .o_redirect    (redirect),
    .o_redirect_pc (redirect_pc),
    .o_mie         (mie)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_failures++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] csr_instr(input logic [11:0] a, input logic [2:0] f3,
                                            input logic [4:0] rs1f);
    return {a, rs1f, f3, 5'd1, 7'h73};
  endfunction

  function automatic bit m_known(input logic [11:0] a);
    case (a)
      12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343: return 1'b1;
`ifdef RISCV_CSR_COUNTERS_EN
      12'hB00, 12'hB02, 12'hB80, 12'hB82: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    if (a == 12'h300) return 32'h0000_1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
    if (a == 12'h301) return 32'h4000_0100;
    if (m_csr.exists(int'(a))) return m_csr[int'(a)];
    return 32'h0;
  endfunction

  function automatic void m_write(input logic [11:0] a, input logic [31:0] v);
    if (a == 12'h300) begin
      m_mie  = v[3];
      m_mpie = v[7];
    end else if (a == 12'h305 || a == 12'h341) begin
      m_csr[int'(a)] = v & 32'hFFFF_FFFC;
    end else begin
      m_csr[int'(a)] = v;
    end
  endfunction

  function automatic void m_reset();
    m_csr.delete();
    m_csr[int'(12'h305)] = 32'h0000_0100;
    m_csr[int'(12'h340)] = 32'h0;
    m_csr[int'(12'h341)] = 32'h0;
    m_csr[int'(12'h342)] = 32'h0;
    m_csr[int'(12'h343)] = 32'h0;
    m_mie  = 1'b0;
    m_mpie = 1'b0;
  endfunction

  task automatic clear_inputs();
    valid = 0; instr = 0; pc = 0; rs1_data = 0;
    ecall = 0; ebreak = 0; mret = 0; sret = 0; csr_wen = 0; illegal = 0;
  endtask

  // Inputs that would have effects if accepted; the DUT must ignore them while busy
  task automatic drive_junk();
    valid    = 1'b1;
    instr    = csr_instr(12'h340, 3'b001, 5'd3);
    rs1_data = $urandom;
    csr_wen  = 1'b1;
    ecall    = 1'($urandom_range(0, 1));
    mret     = 1'($urandom_range(0, 1));
  endtask

  // Called at the first negedge after the trigger edge
  task automatic redirect_seq(input string tag, input logic [31:0] exp_pc);
    drive_junk();
    #1;
    check({tag, "/busy_stall"}, 32'(stall), 32'd1);
    check({tag, "/busy_redirect"}, 32'(redirect), 32'd0);
    @(negedge clk);
    drive_junk();
    #1;
    check({tag, "/redir_pulse"}, 32'({redirect, flush, stall}), 32'b111);
    check({tag, "/redir_pc"}, redirect_pc, exp_pc);
    @(negedge clk);
    clear_inputs();
    #1;
    check({tag, "/back_idle"}, 32'({redirect, flush, stall}), 32'b000);
  endtask

  // One instruction presented in IDLE for one cycle, checked against the model
  task automatic issue(input string tag, input bit v, input logic [31:0] ins,
                       input logic [31:0] p, input logic [31:0] r1,
                       input bit f_ecall, input bit f_ebreak, input bit f_mret,
                       input bit f_sret, input bit f_ill);
    logic [2:0]  f3;
    logic [11:0] a;
    logic [4:0]  rf;
    logic [31:0] opnd, old, nv, cause, tval, exp_pc;
    bit          is_csr, wr, bad, trap, do_mret;
    valid = v; instr = ins; pc = p; rs1_data = r1;
    ecall = f_ecall; ebreak = f_ebreak; mret = f_mret; sret = f_sret; illegal = f_ill;
    csr_wen = (ins[6:0] == 7'h73);
    #1;
    check({tag, "/idle_stall"}, 32'(stall), 32'd0);
    check({tag, "/mie"}, 32'(mie), 32'(m_mie));
    f3     = ins[14:12];
    a      = ins[31:20];
    rf     = ins[19:15];
    is_csr = v && csr_wen && (f3 != 3'b000);
    opnd   = f3[2] ? {27'd0, rf} : r1;
    wr     = is_csr && ((f3[1:0] == 2'b01) || ((f3[1:0] != 2'b00) && (rf != 5'd0)));
    bad    = is_csr && (!m_known(a) || (a == 12'h301 && wr));
    trap = 0; cause = 0; tval = 0;
    if (v) begin
      if (f_ill || f_sret) begin trap = 1; cause = 2;  tval = ins; end
      else if (bad)        begin trap = 1; cause = 2;  tval = ins; end
      else if (f_ecall)    begin trap = 1; cause = 11; tval = 0;   end
      else if (f_ebreak)   begin trap = 1; cause = 3;  tval = p;   end
    end
    do_mret = v && f_mret && !trap;
    old = m_read(a);
    if (is_csr && !trap && m_known(a)) check({tag, "/rdata"}, csr_rdata, old);
    exp_pc = 0;
    if (trap) begin
      m_csr[int'(12'h341)] = p & 32'hFFFF_FFFC;
      m_csr[int'(12'h342)] = cause;
      m_csr[int'(12'h343)] = tval;
      m_mpie = m_mie;
      m_mie  = 1'b0;
      exp_pc = m_csr[int'(12'h305)];
    end else if (do_mret) begin
      m_mie  = m_mpie;
      m_mpie = 1'b1;
      exp_pc = m_csr[int'(12'h341)];
    end else if (wr) begin
      case (f3[1:0])
        2'b01:   nv = opnd;
        2'b10:   nv = old | opnd;
        default: nv = old & ~opnd;
      endcase
      m_write(a, nv);
    end
    @(negedge clk);
    if (trap || do_mret) redirect_seq(tag, exp_pc);
    clear_inputs();
  endtask

  // Pure CSR read (CSRRS rd, csr, x0) checked against an explicit value
  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    valid   = 1'b1;
    instr   = csr_instr(a, 3'b010, 5'd0);
    csr_wen = 1'b1;
    #1;
    check({tag, "/stall"}, 32'(stall), 32'd0);
    check(tag, csr_rdata, exp);
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic drive_raw(input logic [31:0] ins, input logic [31:0] r1);
    valid = 1'b1; instr = ins; rs1_data = r1; csr_wen = 1'b1;
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    int          k;
    logic [11:0] ra;
    logic [4:0]  rrf;
    logic [31:0] rp;

    clear_inputs();
    rst_n = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    #1;
    check("reset/outputs", 32'({stall, flush, redirect, mie}), 32'd0);
    check("reset/redirect_pc", redirect_pc, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    rd("reset/mtvec", 12'h305, 32'h0000_0100);
    rd("reset/mstatus", 12'h300, 32'h0000_1800);
    rd("reset/misa", 12'h301, 32'h4000_0100);

    // Basic CSR read/modify/write
    issue("rw_mscratch", 1, csr_instr(12'h340, 3'b001, 5'd2), 0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
    rd("mscratch_deadbeef", 12'h340, 32'hDEAD_BEEF);
    issue("rw_f0", 1, csr_instr(12'h340, 3'b001, 5'd2), 0, 32'h0000_00F0, 0, 0, 0, 0, 0);
    issue("csrrsi_0f", 1, csr_instr(12'h340, 3'b110, 5'h0F), 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
    issue("csrrc_30", 1, csr_instr(12'h340, 3'b011, 5'd2), 0, 32'h0000_0030, 0, 0, 0, 0, 0);
    rd("mscratch_cf", 12'h340, 32'h0000_00CF);
    issue("csrrs_x0", 1, csr_instr(12'h340, 3'b010, 5'd0), 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
    rd("mscratch_still_cf", 12'h340, 32'h0000_00CF);

    // ECALL with MIE set, then MRET back
    issue("set_mie", 1, csr_instr(12'h300, 3'b110, 5'd8), 0, 0, 0, 0, 0, 0, 0);
    issue("ecall", 1, 32'h0000_0073, 32'h0000_0200, 0, 1, 0, 0, 0, 0);
    rd("ecall/mepc", 12'h341, 32'h0000_0200);
    rd("ecall/mcause", 12'h342, 32'd11);
    rd("ecall/mtval", 12'h343, 32'h0);
    rd("ecall/mstatus", 12'h300, 32'h0000_1880);
    issue("mret", 1, 32'h3020_0073, 32'h0000_0204, 0, 0, 0, 1, 0, 0);
    rd("mret/mstatus", 12'h300, 32'h0000_1888);

    // Illegal sources and breakpoints
    issue("bad_csr", 1, 32'h7FF0_2073, 32'h0000_0300, 0, 0, 0, 0, 0, 0);
    rd("bad_csr/mcause", 12'h342, 32'd2);
    rd("bad_csr/mtval", 12'h343, 32'h7FF0_2073);
    issue("sret", 1, 32'h1020_0073, 32'h0000_0304, 0, 0, 0, 0, 1, 0);
    rd("sret/mcause", 12'h342, 32'd2);
    rd("sret/mtval", 12'h343, 32'h1020_0073);
    issue("ebreak", 1, 32'h0010_0073, 32'h0000_0346, 0, 0, 1, 0, 0, 0);
    rd("ebreak/mcause", 12'h342, 32'd3);
    rd("ebreak/mtval", 12'h343, 32'h0000_0346);
    rd("ebreak/mepc_aligned", 12'h341, 32'h0000_0344);
    issue("misa_write", 1, csr_instr(12'h301, 3'b001, 5'd5), 32'h0000_0400, 32'h1234, 0, 0, 0, 0, 0);
    rd("misa_write/mcause", 12'h342, 32'd2);
    rd("misa_unchanged", 12'h301, 32'h4000_0100);
    issue("mtvec_write", 1, csr_instr(12'h305, 3'b001, 5'd4), 0, 32'h0000_1233, 0, 0, 0, 0, 0);
    rd("mtvec_masked", 12'h305, 32'h0000_1230);
    issue("invalid_ecall", 0, 32'h0000_0073, 32'h0000_0500, 0, 1, 0, 0, 0, 0);
    rd("invalid/mcause", 12'h342, 32'd2);

`ifdef RISCV_CSR_COUNTERS_EN
    drive_raw(csr_instr(12'hB80, 3'b001, 5'd6), 32'h0);
    drive_raw(csr_instr(12'hB00, 3'b001, 5'd6), 32'hFFFF_FFFF);
    rd("mcycle_lo", 12'hB00, 32'hFFFF_FFFF);
    rd("mcycleh_carry", 12'hB80, 32'h0000_0001);
`else
    issue("mcycle_unknown", 1, csr_instr(12'hB00, 3'b010, 5'd0), 32'h0000_0408, 0, 0, 0, 0, 0, 0);
    rd("mcycle_unknown/mcause", 12'h342, 32'd2);
`endif

    // Reset while in TRAP: no redirect, CSRs back to reset values
    issue("mtvec_400", 1, csr_instr(12'h305, 3'b001, 5'd7), 0, 32'h0000_0400, 0, 0, 0, 0, 0);
    valid = 1'b1; instr = 32'h0000_0073; pc = 32'h0000_0500; ecall = 1'b1; csr_wen = 1'b1;
    @(negedge clk);
    clear_inputs();
    #1;
    check("rst_mid/in_trap", 32'(stall), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid/stall", 32'(stall), 32'd0);
    check("rst_mid/redirect_pc", redirect_pc, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("rst_mid/no_redirect", 32'({redirect, flush}), 32'd0);
    end
    rst_n = 1'b1;
    m_reset();
    @(negedge clk);
    rd("rst_mid/mtvec", 12'h305, 32'h0000_0100);
    rd("rst_mid/mscratch", 12'h340, 32'h0);
    rd("rst_mid/mepc", 12'h341, 32'h0);

    // Randomized instruction stream against the model
    for (int i = 0; i < 300; i++) begin
      k  = $urandom_range(0, 9);
      rp = $urandom;
      case (k)
        0, 1, 2, 3, 4: begin
          ra  = rnd_addrs[$urandom_range(0, 7)];
          rrf = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          issue("rnd_csr", 1, csr_instr(ra, rnd_f3s[$urandom_range(0, 5)], rrf),
                rp, $urandom, 0, 0, 0, 0, 0);
        end
        5: issue("rnd_ecall", 1, 32'h0000_0073, rp, 0, 1, 0, 0, 0, 0);
        6: issue("rnd_ebreak", 1, 32'h0010_0073, rp, 0, 0, 1, 0, 0, 0);
        7: issue("rnd_mret", 1, 32'h3020_0073, rp, 0, 0, 0, 1, 0, 0);
        8: begin
          if ($urandom_range(0, 1) == 1)
            issue("rnd_sret", 1, 32'h1020_0073, rp, 0, 0, 0, 0, 1, 0);
          else
            issue("rnd_illegal", 1, $urandom, rp, $urandom, 0, 0, 0, 0, 1);
        end
        default: issue("rnd_idle", 0, $urandom, rp, $urandom,
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      endcase
    end

    for (int j = 0; j < 7; j++) rd("final_sweep", rnd_addrs[j], m_read(rnd_addrs[j]));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule

`default_nettype wire
